// File: rtl/bp_cce_dir_inv_walker.sv
// ---------------------------------------------------------------------------
// bp_cce_dir_inv_walker
//
// Invalidation sequencer on the initiator side of the CCE directory
// interface. One request names a block address and a requesting LCE. The
// walker reads the way-group from the directory and latches the sharers
// vector with the requester masked out. It then visits each remaining
// sharer in ascending LCE order. For each one it sends an invalidate
// command to the LCE, then writes that LCE's directory entry to Invalid.
//
// Optional feature macro: BP_CCE_DIR_INV_WALKER_OVERLAP_EN
//   When defined, the directory write is folded into the invalidate
//   handshake cycle if the directory is free. This brings the cost down to
//   2 cycles per sharer. When undefined, WRITE is always its own state.
//
// Ports
//   clk_i, reset_i              clock, asynchronous active-high reset
//   start_v_i / start_ready_o   request handshake (addr_i, req_lce_i)
//   dir_busy_i                  directory cannot take a command this cycle
//   dir_r_v_o                   read-way-group command
//   dir_w_v_o                   entry write (dir_lce_o, dir_way_o,
//                               dir_coh_state_o = Invalid)
//   dir_addr_o                  latched block address
//   dir_sharers_*_i             returned sharers vector (hits, ways)
//   inv_v_o / inv_ready_i       invalidate command (inv_lce_o, inv_way_o,
//                               inv_addr_o)
//   done_v_o                    one-cycle completion pulse
//   done_count_o                invalidates issued; held until next start
// ---------------------------------------------------------------------------
module bp_cce_dir_inv_walker #(
  parameter int num_lce_p         = 4,
  parameter int lce_assoc_width_p = 3,
  parameter int paddr_width_p     = 40,
  parameter int coh_state_width_p = 3,
  localparam int lce_id_width_lp  = (num_lce_p > 1) ? $clog2(num_lce_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   start_v_i,
  output logic                                   start_ready_o,
  input  logic [paddr_width_p-1:0]               addr_i,
  input  logic [lce_id_width_lp-1:0]             req_lce_i,
  input  logic                                   dir_busy_i,
  output logic                                   dir_r_v_o,
  output logic                                   dir_w_v_o,
  output logic [paddr_width_p-1:0]               dir_addr_o,
  output logic [lce_id_width_lp-1:0]             dir_lce_o,
  output logic [lce_assoc_width_p-1:0]           dir_way_o,
  output logic [coh_state_width_p-1:0]           dir_coh_state_o,
  input  logic                                   dir_sharers_v_i,
  input  logic [num_lce_p-1:0]                   dir_sharers_hits_i,
  input  logic [num_lce_p*lce_assoc_width_p-1:0] dir_sharers_ways_i,
  output logic                                   inv_v_o,
  input  logic                                   inv_ready_i,
  output logic [lce_id_width_lp-1:0]             inv_lce_o,
  output logic [lce_assoc_width_p-1:0]           inv_way_o,
  output logic [paddr_width_p-1:0]               inv_addr_o,
  output logic                                   done_v_o,
  output logic [lce_id_width_lp:0]               done_count_o
);

  localparam int cnt_width_lp = lce_id_width_lp + 1;

  typedef enum logic [2:0] {
    e_idle, e_read, e_wait, e_scan, e_inv, e_write, e_done
  } state_e;

  state_e                                 state_q, state_d;
  logic [paddr_width_p-1:0]               addr_q, addr_d;
  logic [lce_id_width_lp-1:0]             req_lce_q, req_lce_d;
  logic [lce_id_width_lp-1:0]             cur_lce_q, cur_lce_d;
  logic [num_lce_p-1:0]                   pending_q, pending_d;
  logic [num_lce_p*lce_assoc_width_p-1:0] ways_q, ways_d;
  logic [cnt_width_lp-1:0]                count_q, count_d;

  logic [num_lce_p-1:0]         req_mask, cur_mask;
  logic [lce_id_width_lp-1:0]   scan_lce;
  logic [lce_assoc_width_p-1:0] cur_way;
  logic [cnt_width_lp-1:0]      count_inc;

  // A requester id outside the LCE range matches no bit, so nothing is masked.
  // The encoder walks downward so that the lowest pending bit is written last.
  always_comb begin
    req_mask = '0;
    cur_mask = '0;
    scan_lce = '0;
    cur_way  = '0;
    for (int i = 0; i < num_lce_p; i++) begin
      req_mask[i] = (req_lce_q == lce_id_width_lp'(i));
      cur_mask[i] = (cur_lce_q == lce_id_width_lp'(i));
      if (cur_lce_q == lce_id_width_lp'(i))
        cur_way = ways_q[i*lce_assoc_width_p +: lce_assoc_width_p];
    end
    for (int i = num_lce_p - 1; i >= 0; i--)
      if (pending_q[i]) scan_lce = lce_id_width_lp'(i);
  end

  // The count saturates at num_lce_p.
  assign count_inc = (count_q == cnt_width_lp'(num_lce_p)) ? count_q : count_q + 1'b1;

  // NOTE: every signal driven here gets a default first. A path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    req_lce_d     = req_lce_q;
    cur_lce_d     = cur_lce_q;
    pending_d     = pending_q;
    ways_d        = ways_q;
    count_d       = count_q;
    start_ready_o = 1'b0;
    dir_r_v_o     = 1'b0;
    dir_w_v_o     = 1'b0;
    inv_v_o       = 1'b0;
    done_v_o      = 1'b0;

    unique case (state_q)
      e_idle: begin
        start_ready_o = 1'b1;
        if (start_v_i) begin
          addr_d    = addr_i;
          req_lce_d = req_lce_i;
          count_d   = '0;
          state_d   = e_read;
        end
      end
      e_read: begin
        dir_r_v_o = ~dir_busy_i;
        if (!dir_busy_i) state_d = e_wait;
      end
      e_wait: begin
        if (dir_sharers_v_i) begin
          pending_d = dir_sharers_hits_i & ~req_mask;
          ways_d    = dir_sharers_ways_i;
          state_d   = e_scan;
        end
      end
      e_scan: begin
        if (pending_q == '0) begin
          state_d = e_done;
        end else begin
          cur_lce_d = scan_lce;
          state_d   = e_inv;
        end
      end
      e_inv: begin
        inv_v_o = 1'b1;
        if (inv_ready_i) begin
          count_d = count_inc;
`ifdef BP_CCE_DIR_INV_WALKER_OVERLAP_EN
          if (!dir_busy_i) begin
            dir_w_v_o = 1'b1;
            pending_d = pending_q & ~cur_mask;
            state_d   = e_scan;
          end else begin
            state_d   = e_write;
          end
`else
          state_d = e_write;
`endif
        end
      end
      e_write: begin
        dir_w_v_o = ~dir_busy_i;
        if (!dir_busy_i) begin
          pending_d = pending_q & ~cur_mask;
          state_d   = e_scan;
        end
      end
      e_done: begin
        done_v_o = 1'b1;
        state_d  = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  // NOTE: the latched ways and pending bits are reset along with the state.
  // Every command field therefore reads zero right after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= e_idle;
      addr_q    <= '0;
      req_lce_q <= '0;
      cur_lce_q <= '0;
      pending_q <= '0;
      ways_q    <= '0;
      count_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge value of every other register.
      state_q   <= state_d;
      addr_q    <= addr_d;
      req_lce_q <= req_lce_d;
      cur_lce_q <= cur_lce_d;
      pending_q <= pending_d;
      ways_q    <= ways_d;
      count_q   <= count_d;
    end
  end

  assign dir_addr_o      = addr_q;
  assign dir_lce_o       = cur_lce_q;
  assign dir_way_o       = cur_way;
  assign dir_coh_state_o = '0;
  assign inv_lce_o       = cur_lce_q;
  assign inv_way_o       = cur_way;
  assign inv_addr_o      = addr_q;
  assign done_count_o    = count_q;

endmodule

// File: tb/tb_bp_cce_dir_inv_walker.sv
// ---------------------------------------------------------------------------
// Self-checking bench for bp_cce_dir_inv_walker.
//
// The reference model works at the transaction level. For each request it
// builds the ordered list of LCEs that must be invalidated: the ascending
// hit bits, minus the requester. It then follows the handshake timing
// rules:
//   - the read follows the start;
//   - an invalidate or done appears two cycles after the sharers capture
//     or after the previous write;
//   - each write follows its invalidate, and coincides with it when
//     overlap is enabled and the directory is free.
// Inputs are driven on the falling edge, and outputs are sampled 1 ns
// later, before the next rising edge.
// ---------------------------------------------------------------------------
module tb_bp_cce_dir_inv_walker;
  localparam int N = 4, A = 3, P = 40, C = 3, L = 2;
`ifdef BP_CCE_DIR_INV_WALKER_OVERLAP_EN
  localparam bit overlap = 1'b1;
`else
  localparam bit overlap = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic           start_v_i, start_ready_o;
  logic [P-1:0]   addr_i;
  logic [L-1:0]   req_lce_i;
  logic           dir_busy_i, dir_r_v_o, dir_w_v_o;
  logic [P-1:0]   dir_addr_o;
  logic [L-1:0]   dir_lce_o;
  logic [A-1:0]   dir_way_o;
  logic [C-1:0]   dir_coh_state_o;
  logic           dir_sharers_v_i;
  logic [N-1:0]   dir_sharers_hits_i;
  logic [N*A-1:0] dir_sharers_ways_i;
  logic           inv_v_o, inv_ready_i;
  logic [L-1:0]   inv_lce_o;
  logic [A-1:0]   inv_way_o;
  logic [P-1:0]   inv_addr_o;
  logic           done_v_o;
  logic [L:0]     done_count_o;

  int n_vec = 0;
  int n_err = 0;

  bp_cce_dir_inv_walker #(
    .num_lce_p(N), .lce_assoc_width_p(A), .paddr_width_p(P), .coh_state_width_p(C)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .start_v_i(start_v_i), .start_ready_o(start_ready_o),
    .addr_i(addr_i), .req_lce_i(req_lce_i),
    .dir_busy_i(dir_busy_i), .dir_r_v_o(dir_r_v_o), .dir_w_v_o(dir_w_v_o),
    .dir_addr_o(dir_addr_o), .dir_lce_o(dir_lce_o), .dir_way_o(dir_way_o),
    .dir_coh_state_o(dir_coh_state_o),
    .dir_sharers_v_i(dir_sharers_v_i), .dir_sharers_hits_i(dir_sharers_hits_i),
    .dir_sharers_ways_i(dir_sharers_ways_i),
    .inv_v_o(inv_v_o), .inv_ready_i(inv_ready_i),
    .inv_lce_o(inv_lce_o), .inv_way_o(inv_way_o), .inv_addr_o(inv_addr_o),
    .done_v_o(done_v_o), .done_count_o(done_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_rdy"}, start_ready_o, 1);
    check({tag, "_rd_v"}, dir_r_v_o, 0);
    check({tag, "_wr_v"}, dir_w_v_o, 0);
    check({tag, "_inv_v"}, inv_v_o, 0);
    check({tag, "_done_v"}, done_v_o, 0);
    check({tag, "_done_cnt"}, done_count_o, 0);
    check({tag, "_dir_addr"}, dir_addr_o, 0);
    check({tag, "_inv_addr"}, inv_addr_o, 0);
    check({tag, "_inv_lce"}, inv_lce_o, 0);
    check({tag, "_inv_way"}, inv_way_o, 0);
    check({tag, "_dir_lce"}, dir_lce_o, 0);
    check({tag, "_dir_way"}, dir_way_o, 0);
    check({tag, "_coh"}, dir_coh_state_o, 0);
  endtask

  // busy_mode:  0 random, 1 never busy, 2 busy 4 cycles after start and 2 cycles per write
  // ready_mode: 0 random, 1 always ready, 2 ready only after 5 stall cycles per command
  // abort_at:   >0 asserts reset while the command after that many handshakes is pending
  task automatic run_txn(input logic [P-1:0] addr, input int req, input logic [N-1:0] hits,
                         input logic [N*A-1:0] ways, input int busy_mode, input int ready_mode,
                         input int abort_at);
    int exp_lce[$];
    int exp_way[$];
    int cyc = 0, ev_at = -1, inv_n = 0, wr_n = 0, n_exp, stall = 0, wr_busy = 0;
    int last_hs = -1, sv_delay, wait_cnt = 0, hs_lce = 0, hs_way = 0;
    bit rd_issued = 0, cap_done = 0, wr_pending = 0, done_seen = 0;
    bit inv_exp, w_exp, rd_before, done_exp;
    logic busy, rdy;
    logic [63:0] r64;

    for (int i = 0; i < N; i++)
      if (hits[i] && i != req) begin
        exp_lce.push_back(i);
        exp_way.push_back(int'(ways[i*A +: A]));
      end
    n_exp    = exp_lce.size();
    sv_delay = $urandom_range(0, 2);

    while (!done_seen && cyc < 400) begin
      @(negedge clk_i);
      inv_exp = (ev_at >= 0) && (cyc >= ev_at) && (exp_lce.size() > 0);
      case (busy_mode)
        1:       busy = 1'b0;
        2:       busy = (cyc >= 1 && cyc <= 4) || (wr_pending && wr_busy > 0);
        default: busy = ($urandom_range(0, 2) == 0);
      endcase
      if (wr_pending && wr_busy > 0) wr_busy--;
      case (ready_mode)
        1:       rdy = 1'b1;
        2:       rdy = inv_exp ? (stall >= 5) : 1'($urandom_range(0, 1));
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (inv_exp && !rdy) stall++;

      // Garbage on start/addr/req after the first cycle must be ignored.
      r64        = {$urandom, $urandom};
      start_v_i  = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      addr_i     = (cyc == 0) ? addr : r64[P-1:0];
      req_lce_i  = (cyc == 0) ? L'(req) : L'($urandom_range(0, N - 1));
      dir_busy_i = busy;
      inv_ready_i = rdy;
      if (rd_issued && !cap_done) begin
        dir_sharers_v_i    = (wait_cnt == sv_delay);
        dir_sharers_hits_i = (wait_cnt == sv_delay) ? hits : N'($urandom);
        dir_sharers_ways_i = (wait_cnt == sv_delay) ? ways : (N*A)'($urandom);
        wait_cnt++;
      end else begin
        dir_sharers_v_i    = 1'($urandom_range(0, 1));
        dir_sharers_hits_i = N'($urandom);
        dir_sharers_ways_i = (N*A)'($urandom);
      end
      #1;

      if (abort_at > 0 && inv_exp && inv_n == abort_at) begin
        check("abort_in_inv", inv_v_o, 1);
        start_v_i   = 1'b0;
        inv_ready_i = 1'b0;
        reset_i     = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk_i);
        dir_sharers_v_i = 1'b0;
        reset_i = 1'b0;
        return;
      end

      rd_before = rd_issued;
      if (cyc == 0) check("start_rdy", start_ready_o, 1);
      else          check("busy_no_rdy", start_ready_o, 0);
      check("rw_excl", dir_r_v_o & dir_w_v_o, 0);

      if (cyc > 0 && !rd_issued) begin
        check("rd_v", dir_r_v_o, !busy);
        if (!busy) begin
          check("rd_addr", dir_addr_o, addr);
          rd_issued = 1;
        end
      end else begin
        check("rd_quiet", dir_r_v_o, 0);
      end
      if (rd_before && !cap_done && dir_sharers_v_i) begin
        cap_done = 1;
        ev_at    = cyc + 2;
      end

      check("inv_v", inv_v_o, inv_exp);
      w_exp = wr_pending ? !busy : 1'b0;
      if (inv_exp) begin
        check("inv_lce", inv_lce_o, exp_lce[0]);
        check("inv_way", inv_way_o, exp_way[0]);
        check("inv_addr", inv_addr_o, addr);
        if (rdy) begin
          if (last_hs >= 0 && busy_mode == 1 && ready_mode == 1)
            check("inv_spacing", cyc - last_hs, overlap ? 2 : 3);
          last_hs = cyc;
          inv_n++;
          stall  = 0;
          hs_lce = exp_lce.pop_front();
          hs_way = exp_way.pop_front();
          if (overlap && !busy) begin
            w_exp = 1'b1;
            ev_at = cyc + 2;
          end else begin
            wr_pending = 1;
            wr_busy    = 2;
            ev_at      = -1;
          end
        end
      end

      check("wr_v", dir_w_v_o, w_exp);
      if (w_exp) begin
        check("wr_lce", dir_lce_o, hs_lce);
        check("wr_way", dir_way_o, hs_way);
        check("wr_coh", dir_coh_state_o, 0);
        check("wr_addr", dir_addr_o, addr);
        wr_n++;
        if (wr_pending) begin
          wr_pending = 0;
          ev_at      = cyc + 2;
        end
      end

      done_exp = (ev_at == cyc) && (exp_lce.size() == 0);
      check("done_v", done_v_o, done_exp);
      if (done_exp) begin
        check("done_count", done_count_o, n_exp);
        check("inv_total", inv_n, n_exp);
        check("wr_total", wr_n, n_exp);
        done_seen = 1;
      end
      cyc++;
    end
    check("finished", done_seen, 1);

    @(negedge clk_i);
    start_v_i       = 1'b0;
    dir_sharers_v_i = 1'b0;
    #1;
    check("rdy_after_done", start_ready_o, 1);
    check("done_one_cycle", done_v_o, 0);
    check("count_held", done_count_o, n_exp);
  endtask

  initial begin
    logic [63:0]    r64;
    logic [N*A-1:0] wv;
    reset_i = 1'b1;
    start_v_i = 1'b0; addr_i = '0; req_lce_i = '0; dir_busy_i = 1'b0;
    dir_sharers_v_i = 1'b0; dir_sharers_hits_i = '0; dir_sharers_ways_i = '0;
    inv_ready_i = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk_i);
    reset_i = 1'b0;

    wv = {3'd7, 3'd5, 3'd2, 3'd3};
    run_txn(40'h12_3456_7890, 1, 4'b1011, wv, 1, 1, 0);
    run_txn(40'h00_0000_0040, 1, 4'b1011, wv, 0, 0, 0);
    run_txn(40'hab_cdef_0100, 1, 4'b0010, wv, 0, 0, 0);
    run_txn(40'h55_aa55_aa00, 0, 4'b1111, {3'd1, 3'd6, 3'd4, 3'd0}, 1, 2, 0);
    run_txn(40'h01_0203_0400, 1, 4'b1011, wv, 2, 1, 0);
    run_txn(40'h77_0000_1000, 1, 4'b1011, wv, 1, 1, 1);
    run_txn(40'h88_0000_2000, 1, 4'b1011, wv, 1, 1, 0);
    run_txn(40'h99_0000_3000, 3, 4'b1110, {3'd2, 3'd4, 3'd6, 3'd1}, 1, 1, 0);

    for (int t = 0; t < 40; t++) begin
      r64 = {$urandom, $urandom};
      run_txn(r64[P-1:0], $urandom_range(0, N - 1), N'($urandom), (N*A)'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
